// File: rtl/div_seq_ctrl_if.sv
// Operand/result bundle between a divide requester and div_seq_ctrl.
// The requester drives the operands and start; the divider answers with busy/done/result.
interface div_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider, signed or unsigned, remainder in the upper half of result.
// Latency: done WIDTH+3 cycles after accept (2 cycles for a zero divisor).
// Backpressure: none; start is only taken while idle, otherwise ignored.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          clear,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIXUP,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   qd;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   cnt;
  logic               signed_op;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] result_r;
  logic               div_by_zero_r;

  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;

  // Partial remainder is below the divisor, so the true difference always fits in WIDTH bits.
  assign rem_shift = {rem, qd[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvs};
  assign rem_diff  = rem_shift[WIDTH-1:0] - dvs;

  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= IDLE;
      qd            <= '0;
      dvs           <= '0;
      rem           <= '0;
      cnt           <= '0;
      signed_op     <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dbz           <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      result_r      <= '0;
      div_by_zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            qd        <= bus.dividend;
            dvs       <= bus.divisor;
            signed_op <= bus.is_signed;
            busy_r    <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          cnt <= '0;
          if (dvs == '0) begin
            // qd still holds the raw captured dividend here
            qd    <= '1;
            rem   <= qd;
            dbz   <= 1'b1;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= DONE;
          end else begin
            rem   <= '0;
            dbz   <= 1'b0;
            neg_q <= signed_op & (qd[WIDTH-1] ^ dvs[WIDTH-1]);
            neg_r <= signed_op & qd[WIDTH-1];
            if (signed_op && qd[WIDTH-1]) qd <= -qd;
            if (signed_op && dvs[WIDTH-1]) dvs <= -dvs;
            state <= ITER;
          end
        end
        ITER: begin
          qd  <= {qd[WIDTH-2:0], rem_ge};
          rem <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == WIDTH'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          if (neg_q) qd <= -qd;
          if (neg_r) rem <= -rem;
          state <= DONE;
        end
        DONE: begin
          result_r      <= {rem, qd};
          div_by_zero_r <= dbz;
          done_r        <= 1'b1;
          busy_r        <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result      = result_r;
  assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand width; result is 2*WIDTH.
REQ-002 Port: clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: clear  in  1  reset; synchronous, active-high.
REQ-004 Port: start  in  1  request a division; sampled only in IDLE.
REQ-005 Port: is_signed  in  1  1 = two's-complement divide, 0 = unsigned; captured with start.
REQ-006 Port: dividend  in  WIDTH  numerator; captured with start.
REQ-007 Port: divisor  in  WIDTH  denominator; captured with start.
REQ-008 Port: busy  out  1  high whenever state is not IDLE.
REQ-009 Port: done  out  1  one-cycle pulse; result and div_by_zero are valid in that cycle.
REQ-010 Port: result  out  2*WIDTH  [WIDTH-1:0] = quotient, [2*WIDTH-1:WIDTH] = remainder.
REQ-011 Port: div_by_zero  out  1  set when the completed operation had divisor 0.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, ITER, FIXUP and DONE; encoding is free.
REQ-013 IDLE with start=1 at edge N SHALL capture the operands and is_signed, and enter SETUP.
REQ-014 SETUP SHALL go to DONE if the divisor is 0, else to ITER.
REQ-015 In SETUP, signed mode SHALL use absolute values and record the quotient sign (sign(dividend) XOR sign(divisor)) and remainder sign (sign(dividend)); unsigned mode uses raw values.
REQ-016 ITER SHALL run exactly WIDTH cycles, one restoring shift-subtract step per cycle, MSB first, with a WIDTH-bit iteration counter.
REQ-017 Each step: remainder = (remainder<<1)|next dividend bit; if remainder >= divisor, subtract and shift 1 into the quotient, else shift 0.
REQ-018 ITER SHALL go to FIXUP after the WIDTH-th step; FIXUP SHALL negate quotient and/or remainder per the recorded signs (signed mode only), then go to DONE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 Latency: done SHALL be high in the cycle after edge N+WIDTH+3 (N+35 for WIDTH=32) for a nonzero divisor, and after edge N+2 for a zero divisor.
REQ-021 Divide-by-zero result SHALL be quotient all ones and remainder equal to the captured dividend, with div_by_zero=1.
REQ-022 Signed overflow (most-negative / -1) SHALL give quotient = most-negative value, remainder 0, div_by_zero=0.
REQ-023 start SHALL be ignored in all states other than IDLE, including DONE; operand changes after capture SHALL have no effect.
REQ-024 start may be asserted in the first IDLE cycle after DONE and SHALL be accepted there (back-to-back operation).
REQ-025 result and div_by_zero SHALL hold their last completed values until the next DONE and SHALL NOT show partial values during ITER.

Reset
REQ-026 clear=1 at an edge SHALL force IDLE and set busy=0, done=0, result=0, div_by_zero=0, and zero all internal counters and registers.
REQ-027 clear SHALL take priority over start and over any in-flight operation; an aborted operation SHALL never produce done.

Verification
REQ-028 Unsigned 100/7 -> done exactly 35 cycles after accept, result=0x00000002_0000000E, div_by_zero=0.
REQ-029 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-030 Unsigned 5/0 -> done 2 cycles after accept, quotient 0xFFFFFFFF, remainder 0x00000005, div_by_zero=1.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-032 clear pulsed 10 cycles into an operation -> busy=0 and result=0 next cycle, no done pulse; a following 9/3 completes with quotient 3, remainder 0.
REQ-033 start held high with new operands throughout a 20/6 operation -> only 20/6 is computed (quotient 3, remainder 2); the next operation is accepted in the IDLE cycle after DONE.
